// File: rtl/add_if_pkg.sv
// Shared defaults and vector types for the registered adder slice.
package add_if_pkg;

  localparam int DEFAULT_WIDTH   = 4;
  localparam int DEFAULT_LATENCY = 1;
  localparam int LATENCY_MAX     = 4;

  typedef logic [DEFAULT_WIDTH-1:0] operand_t;
  typedef logic [DEFAULT_WIDTH:0]   sum_t;

endpackage

// File: rtl/add_if_stage.sv
// One pipeline register stage (data + valid) with synchronous active-low clear.
module add_if_stage #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic [W-1:0] out_data,
  output logic         out_valid
);

  logic [W-1:0] data_d, data_q;
  logic         valid_d, valid_q;

  always_comb begin
    data_d  = in_data;
    valid_d = in_valid;
    if (!rst_n) begin
      data_d  = '0;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    data_q  <= data_d;
    valid_q <= valid_d;
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;

endmodule

// File: rtl/add_if_unit.sv
// Registered unsigned adder: full-width sum with carry after LATENCY clock edges.
module add_if_unit
  import add_if_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int LATENCY = DEFAULT_LATENCY
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic [WIDTH:0]   sum,
  output logic             out_valid
);

  if (LATENCY < 1 || LATENCY > LATENCY_MAX) begin : g_bad_latency
    $error("add_if_unit: LATENCY %0d outside 1..%0d", LATENCY, LATENCY_MAX);
  end

  logic [WIDTH:0] sum_d;
  logic [LATENCY:0][WIDTH:0] stage_data;
  logic [LATENCY:0]          stage_valid;

  // Zero-extend before adding so the carry lands in the MSB instead of wrapping.
  always_comb begin
    sum_d = {1'b0, a} + {1'b0, b};
  end

  assign stage_data[0]  = sum_d;
  assign stage_valid[0] = in_valid;

  for (genvar i = 0; i < LATENCY; i++) begin : g_stage
    add_if_stage #(
      .W (WIDTH + 1)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (stage_data[i]),
      .in_valid  (stage_valid[i]),
      .out_data  (stage_data[i+1]),
      .out_valid (stage_valid[i+1])
    );
  end

  assign sum       = stage_data[LATENCY];
  assign out_valid = stage_valid[LATENCY];

endmodule

// File: tb/tb_add_if_unit.sv
// Directed bench: one LATENCY=1 and one LATENCY=3 adder share the same stimulus.
module tb_add_if_unit;

  logic       clk;
  logic       rst_n;
  logic [3:0] a;
  logic [3:0] b;
  logic       in_valid;
  logic [4:0] sum1;
  logic       out_valid1;
  logic [4:0] sum3;
  logic       out_valid3;

  int vectorCount = 0;
  int missCount   = 0;

  add_if_unit #(.WIDTH(4), .LATENCY(1)) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .sum       (sum1),
    .out_valid (out_valid1)
  );

  add_if_unit #(.WIDTH(4), .LATENCY(3)) u_dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .sum       (sum3),
    .out_valid (out_valid3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive on the falling edge, then sample 1 unit after the next rising edge.
  task automatic applyStimulus(input logic [3:0] av, input logic [3:0] bv,
                               input logic vv, input logic rv);
    @(negedge clk);
    a        = av;
    b        = bv;
    in_valid = vv;
    rst_n    = rv;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [4:0] observed,
                             input logic [4:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic checkBoth(input string tag, input logic [4:0] s1, input logic v1,
                           input logic [4:0] s3, input logic v3);
    checkOutput({tag, " sum1"},  sum1, s1);
    checkOutput({tag, " vld1"},  {4'b0000, out_valid1}, {4'b0000, v1});
    checkOutput({tag, " sum3"},  sum3, s3);
    checkOutput({tag, " vld3"},  {4'b0000, out_valid3}, {4'b0000, v3});
  endtask

  initial begin
    a = 4'd0; b = 4'd0; in_valid = 1'b1; rst_n = 1'b0;

    applyStimulus(4'd7, 4'd9, 1'b1, 1'b0);
    applyStimulus(4'd7, 4'd9, 1'b1, 1'b0);
    checkBoth("reset", 5'd0, 1'b0, 5'd0, 1'b0);

    applyStimulus(4'd1, 4'd5, 1'b1, 1'b1);
    checkBoth("first", 5'd6, 1'b1, 5'd0, 1'b0);
    applyStimulus(4'd3, 4'd5, 1'b1, 1'b1);
    checkBoth("step3", 5'd8, 1'b1, 5'd0, 1'b0);
    applyStimulus(4'd4, 4'd5, 1'b1, 1'b1);
    checkBoth("step4", 5'd9, 1'b1, 5'd6, 1'b1);
    applyStimulus(4'd5, 4'd5, 1'b1, 1'b1);
    checkBoth("step5", 5'd10, 1'b1, 5'd8, 1'b1);

    // Operand change 8 units after the edge must not disturb the registered sum.
    #7;
    a = 4'd8;
    #1;
    checkOutput("midcycle sum1", sum1, 5'd10);
    checkOutput("midcycle sum3", sum3, 5'd8);
    @(posedge clk);
    #1;
    checkBoth("after mid", 5'd13, 1'b1, 5'd9, 1'b1);

    applyStimulus(4'd15, 4'd15, 1'b1, 1'b1);
    checkBoth("carry max", 5'b11110, 1'b1, 5'd10, 1'b1);
    applyStimulus(4'd15, 4'd1, 1'b1, 1'b1);
    checkBoth("carry 16", 5'd16, 1'b1, 5'd13, 1'b1);

    applyStimulus(4'd2, 4'd3, 1'b1, 1'b1);
    checkBoth("stream0", 5'd5, 1'b1, 5'd30, 1'b1);
    applyStimulus(4'd6, 4'd7, 1'b1, 1'b1);
    checkBoth("stream1", 5'd13, 1'b1, 5'd16, 1'b1);
    applyStimulus(4'd9, 4'd2, 1'b1, 1'b1);
    checkBoth("stream2", 5'd11, 1'b1, 5'd5, 1'b1);
    applyStimulus(4'd12, 4'd7, 1'b1, 1'b1);
    checkBoth("stream3", 5'd19, 1'b1, 5'd13, 1'b1);

    applyStimulus(4'd14, 4'd3, 1'b1, 1'b0);
    checkBoth("midreset", 5'd0, 1'b0, 5'd0, 1'b0);
    applyStimulus(4'd1, 4'd1, 1'b1, 1'b1);
    checkBoth("flushed1", 5'd2, 1'b1, 5'd0, 1'b0);
    applyStimulus(4'd2, 4'd2, 1'b1, 1'b1);
    checkBoth("flushed2", 5'd4, 1'b1, 5'd0, 1'b0);

    applyStimulus(4'd3, 4'd4, 1'b1, 1'b1);
    checkBoth("vtog0", 5'd7, 1'b1, 5'd2, 1'b1);
    applyStimulus(4'd5, 4'd6, 1'b0, 1'b1);
    checkBoth("vtog1", 5'd11, 1'b0, 5'd4, 1'b1);
    applyStimulus(4'd7, 4'd7, 1'b1, 1'b1);
    checkBoth("vtog2", 5'd14, 1'b1, 5'd7, 1'b1);
    applyStimulus(4'd1, 4'd2, 1'b1, 1'b1);
    checkBoth("vtog3", 5'd3, 1'b1, 5'd11, 1'b0);
    applyStimulus(4'd0, 4'd1, 1'b1, 1'b1);
    checkBoth("vtog4", 5'd1, 1'b1, 5'd14, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
